// File: rtl/beta_pkg.sv
// Shared types for the beta core memory subsystem: requester identities and
// the unified-port arbiter states.
package beta_pkg;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_INSTR = 2'd1,
    SRC_RD    = 2'd2,
    SRC_WR    = 2'd3
  } mem_src_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/beta_mem_arb_select.sv
// Combinational winner picker: write > read > fetch, with a starving fetch
// promoted above everything.
module beta_mem_arb_select
  import beta_pkg::*;
(
  input  logic     instr_req,
  input  logic     rd_req,
  input  logic     wr_req,
  input  logic     starve,
  output mem_src_e src
);

  always_comb begin
    src = SRC_NONE;
    if (instr_req && starve) begin
      src = SRC_INSTR;
    end else if (wr_req) begin
      src = SRC_WR;
    end else if (rd_req) begin
      src = SRC_RD;
    end else if (instr_req) begin
      src = SRC_INSTR;
    end
  end

endmodule

// File: rtl/beta_mem_arbiter.sv
// Shares one unified memory port between fetch, load and store requesters,
// one transaction in flight at a time.
module beta_mem_arbiter
  import beta_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int StarveLimit  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      instr_req_i,
  input  logic [AddressWidth-1:0]   instr_addr_i,
  output logic                      instr_ready_o,
  output logic                      instr_valid_o,
  output logic [DataWidth-1:0]      instr_rdata_o,
  input  logic                      rdata_req_i,
  input  logic [AddressWidth-1:0]   rdata_addr_i,
  input  logic [DataWidth/8-1:0]    rdata_strb_i,
  output logic                      rdata_ready_o,
  output logic                      rdata_valid_o,
  output logic [DataWidth-1:0]      rdata_data_o,
  input  logic                      wdata_req_i,
  input  logic [AddressWidth-1:0]   wdata_addr_i,
  input  logic [DataWidth-1:0]      wdata_data_i,
  input  logic [DataWidth/8-1:0]    wdata_strb_i,
  output logic                      wdata_ready_o,
  output logic                      wdata_valid_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [AddressWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]      mem_wdata_o,
  output logic [DataWidth/8-1:0]    mem_strb_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_valid_i,
  input  logic [DataWidth-1:0]      mem_rdata_i,
  output logic                      arb_busy_o
);

  localparam int StrbW = DataWidth / 8;
  localparam int CntW  = $clog2(StarveLimit + 1);

  arb_state_e             state;
  mem_src_e               grant;
  mem_src_e               winner;
  logic [CntW-1:0]        starve_cnt;
  logic                   starve;
  logic                   we_p0;
  logic [AddressWidth-1:0] addr_p0;
  logic [DataWidth-1:0]   wdata_p0;
  logic [StrbW-1:0]       strb_p0;
  logic                   issue;
  logic                   accept;
  logic                   resp;

  assign starve = (starve_cnt == CntW'(StarveLimit));

  beta_mem_arb_select u_select (
    .instr_req (instr_req_i),
    .rd_req    (rdata_req_i),
    .wr_req    (wdata_req_i),
    .starve    (starve),
    .src       (winner)
  );

  // Control: FSM, grant and starvation counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ARB_IDLE;
      grant      <= SRC_NONE;
      starve_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (winner != SRC_NONE) begin
            state <= ARB_ISSUE;
            grant <= winner;
          end
          if (winner == SRC_INSTR || !instr_req_i) begin
            starve_cnt <= '0;
          end else if (!starve) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ARB_ISSUE: begin
          if (mem_ready_i) begin
            state <= mem_valid_i ? ARB_IDLE : ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (mem_valid_i) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Payload capture at the grant; outputs are gated by state so no reset needed
  always_ff @(posedge clk_i) begin
    if (state == ARB_IDLE) begin
      we_p0 <= (winner == SRC_WR);
      case (winner)
        SRC_WR: begin
          addr_p0  <= wdata_addr_i;
          wdata_p0 <= wdata_data_i;
          strb_p0  <= wdata_strb_i;
        end
        SRC_RD: begin
          addr_p0  <= rdata_addr_i;
          wdata_p0 <= '0;
          strb_p0  <= rdata_strb_i;
        end
        default: begin
          addr_p0  <= instr_addr_i;
          wdata_p0 <= '0;
          strb_p0  <= '1;
        end
      endcase
    end
  end

  assign issue  = (state == ARB_ISSUE);
  assign accept = issue && mem_ready_i;
  assign resp   = mem_valid_i && (accept || state == ARB_WAIT);

  assign mem_req_o   = issue;
  assign mem_we_o    = issue && we_p0;
  assign mem_addr_o  = issue ? addr_p0  : '0;
  assign mem_wdata_o = issue ? wdata_p0 : '0;
  assign mem_strb_o  = issue ? strb_p0  : '0;

  assign instr_ready_o = accept && (grant == SRC_INSTR);
  assign rdata_ready_o = accept && (grant == SRC_RD);
  assign wdata_ready_o = accept && (grant == SRC_WR);

  assign instr_valid_o = resp && (grant == SRC_INSTR);
  assign rdata_valid_o = resp && (grant == SRC_RD);
  assign wdata_valid_o = resp && (grant == SRC_WR);

  assign instr_rdata_o = instr_valid_o ? mem_rdata_i : '0;
  assign rdata_data_o  = rdata_valid_o ? mem_rdata_i : '0;

  assign arb_busy_o = (state != ARB_IDLE);

endmodule
